// File: rtl/thumb_expand_imm.sv
// Thumb-2 modified-immediate expansion (ThumbExpandImm_C) with registered outputs.
// One-cycle latency, one result per cycle, no backpressure.
module thumb_expand_imm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [11:0] imm12,
  input  logic        carry_in,
  output logic [31:0] imm32,
  output logic        carry_out,
  output logic        out_valid
);

  // Replicated byte patterns selected by imm12[9:8]. A zero byte naturally
  // yields zero, which covers the UNPREDICTABLE encodings.
  function automatic logic [31:0] replicate(input logic [1:0] sel, input logic [7:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (sel)
      2'b00:   v = {24'h0, a};
      2'b01:   v = {8'h0, a, 8'h0, a};
      2'b10:   v = {a, 8'h0, a, 8'h0};
      default: v = {a, a, a, a};
    endcase
    return v;
  endfunction

  // Rotate-right of {1, imm12[6:0]} by imm12[11:7] using a doubled word.
  function automatic logic [31:0] rotate(input logic [11:0] e);
    logic [31:0] unrot;
    logic [63:0] dbl;
    unrot = {24'h0, 1'b1, e[6:0]};
    dbl   = {unrot, unrot} >> e[11:7];
    return dbl[31:0];
  endfunction

  logic [31:0] w_imm32_p0;
  logic        w_carry_p0;

  always_comb begin
    w_imm32_p0 = 32'h0;
    w_carry_p0 = carry_in;
    if (imm12[11:10] == 2'b00) begin
      w_imm32_p0 = replicate(imm12[9:8], imm12[7:0]);
      w_carry_p0 = carry_in;
    end else begin
      w_imm32_p0 = rotate(imm12);
      w_carry_p0 = w_imm32_p0[31];
    end
  end

  // p0 -> p1: output registers; data holds when no valid input is accepted
  logic [31:0] r_imm32_p1;
  logic        r_carry_p1;
  logic        r_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm32_p1 <= 32'h0;
      r_carry_p1 <= 1'b0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_imm32_p1 <= w_imm32_p0;
        r_carry_p1 <= w_carry_p0;
      end
    end
  end

  assign imm32     = r_imm32_p1;
  assign carry_out = r_carry_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_thumb_expand_imm.sv
// Self-checking bench for thumb_expand_imm: directed cases, exhaustive sweep,
// randomized traffic against a behavioural model, hold and async reset.
module tb_thumb_expand_imm;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] imm12;
  logic        carry_in;
  logic [31:0] imm32;
  logic        carry_out;
  logic        out_valid;

  int checks;
  int failures;

  logic [31:0] exp_imm;
  logic        exp_c;
  logic        exp_v;

  thumb_expand_imm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .imm12     (imm12),
    .carry_in  (carry_in),
    .imm32     (imm32),
    .carry_out (carry_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: byte replication by multiplication, rotation bit by bit.
  function automatic logic [32:0] ref_expand(input logic [11:0] e, input logic c);
    logic [31:0] a;
    logic [31:0] v;
    int          r;
    a = {24'h0, e[7:0]};
    if (e[11:10] == 2'b00) begin
      case (e[9:8])
        2'd0:    v = a;
        2'd1:    v = a * 32'h0001_0001;
        2'd2:    v = a * 32'h0100_0100;
        default: v = a * 32'h0101_0101;
      endcase
      return {c, v};
    end
    v = {24'h0, 1'b1, e[6:0]};
    r = int'(e[11:7]);
    for (int k = 0; k < r; k++) v = {v[0], v[31:1]};
    return {v[31], v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one input at the falling edge, sample #1 after the rising edge,
  // update the model and compare all three outputs.
  task automatic step(input logic v, input logic [11:0] e, input logic c);
    logic [32:0] r;
    @(negedge clk);
    in_valid = v;
    imm12    = e;
    carry_in = c;
    @(posedge clk);
    #1;
    if (v) begin
      r       = ref_expand(e, c);
      exp_imm = r[31:0];
      exp_c   = r[32];
    end
    exp_v = v;
    chk("model_imm32", imm32, exp_imm);
    chk("model_carry", {31'h0, carry_out}, {31'h0, exp_c});
    chk("model_valid", {31'h0, out_valid}, {31'h0, exp_v});
  endtask

  initial begin
    logic [11:0] rep [4];
    logic [31:0] rep_exp [4];
    logic [11:0] rot_in [3];
    logic [31:0] rot_exp [3];
    logic        rot_c [3];

    checks = 0; failures = 0;
    exp_imm = 32'h0; exp_c = 1'b0; exp_v = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; imm12 = 12'h3AB; carry_in = 1'b1;

    rep[0] = 12'h0AB; rep_exp[0] = 32'h0000_00AB;
    rep[1] = 12'h1AB; rep_exp[1] = 32'h00AB_00AB;
    rep[2] = 12'h2AB; rep_exp[2] = 32'hAB00_AB00;
    rep[3] = 12'h3AB; rep_exp[3] = 32'hABAB_ABAB;
    rot_in[0] = 12'h400; rot_exp[0] = 32'h8000_0000; rot_c[0] = 1'b1;
    rot_in[1] = 12'h47F; rot_exp[1] = 32'hFF00_0000; rot_c[1] = 1'b1;
    rot_in[2] = 12'hFFF; rot_exp[2] = 32'h0000_01FE; rot_c[2] = 1'b0;

    // Reset held across an edge with valid input present
    @(posedge clk); #1;
    chk("reset_imm32", imm32, 32'h0);
    chk("reset_carry", {31'h0, carry_out}, 32'h0);
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Replicated forms, both carry polarities
    for (int c = 1; c >= 0; c--) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b1, rep[i], c[0]);
        chk("rep_imm32", imm32, rep_exp[i]);
        chk("rep_carry", {31'h0, carry_out}, {31'h0, c[0]});
      end
    end

    // Rotated forms ignore carry_in
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, rot_in[i], c[0]);
        chk("rot_imm32", imm32, rot_exp[i]);
        chk("rot_carry", {31'h0, carry_out}, {31'h0, rot_c[i]});
      end
    end

    // UNPREDICTABLE encodings
    step(1'b1, 12'h100, 1'b1);
    chk("unp100_imm32", imm32, 32'h0);
    chk("unp100_carry", {31'h0, carry_out}, 32'h1);
    step(1'b1, 12'h300, 1'b1);
    chk("unp300_imm32", imm32, 32'h0);
    chk("unp300_carry", {31'h0, carry_out}, 32'h1);

    // Exhaustive sweep, valid every cycle
    for (int n = 0; n < 8192; n++) begin
      logic [12:0] nv;
      nv = n[12:0];
      step(1'b1, nv[11:0], nv[12]);
    end

    // Randomized traffic with random valid gaps
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0), 12'($urandom), 1'($urandom));
    end

    // Handshake and hold
    step(1'b1, 12'h3AB, 1'b0);
    chk("hold_first_imm32", imm32, 32'hABAB_ABAB);
    chk("hold_first_valid", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 12'($urandom), 1'($urandom));
      chk("hold_imm32", imm32, 32'hABAB_ABAB);
      chk("hold_valid", {31'h0, out_valid}, 32'h0);
    end

    // Asynchronous reset between edges
    step(1'b1, 12'h3AB, 1'b1);
    chk("prereset_imm32", imm32, 32'hABAB_ABAB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_imm32", imm32, 32'h0);
    chk("async_reset_carry", {31'h0, carry_out}, 32'h0);
    chk("async_reset_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_imm = 32'h0; exp_c = 1'b0; exp_v = 1'b0;
    step(1'b1, 12'h400, 1'b0);
    chk("post_reset_imm32", imm32, 32'h8000_0000);
    chk("post_reset_carry", {31'h0, carry_out}, 32'h1);
    chk("post_reset_valid", {31'h0, out_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thumb_expand_imm.md
# thumb_expand_imm

Registered implementation of the Thumb-2 modified-immediate expansion (ThumbExpandImm_C). It converts a 12-bit encoded immediate plus the current carry flag into a 32-bit operand and a shifter carry-out. It sits in the decode stage of the Thumb-2 core and feeds the data-processing operand mux and the flag-update logic. Outputs are registered with a one-cycle latency.

## Interface

- No parameters. All widths are fixed by the architecture.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies imm12/carry_in this cycle.
- imm12  input  12  encoded immediate, i:imm3:imm8.
- carry_in  input  1  current APSR.C.
- imm32  output  32  expanded immediate (registered).
- carry_out  output  1  shifter carry-out (registered).
- out_valid  output  1  imm32/carry_out hold a result computed from an accepted input.

## Operation

- Let a = imm12[7:0].
- Replicated forms apply when imm12[11:10] == 2'b00. carry_out = carry_in in all four sub-cases.
  - imm12[9:8] = 00: imm32 = {24'h0, a}.
  - imm12[9:8] = 01: imm32 = {8'h0, a, 8'h0, a}.
  - imm12[9:8] = 10: imm32 = {a, 8'h0, a, 8'h0}.
  - imm12[9:8] = 11: imm32 = {a, a, a, a}.
- Architecturally UNPREDICTABLE encodings (sub-cases 01, 10 and 11 with a == 0) are defined here: imm32 = 0 and carry_out = carry_in. No error flag is raised.
- Rotated form applies when imm12[11:10] != 2'b00.
  - unrot = {24'h0, 1'b1, imm12[6:0]}.
  - rot = imm12[11:7], an unsigned 5-bit value that is always 8..31.
  - imm32 = unrot rotated right by rot. carry_out = imm32[31].
  - carry_in is ignored in the rotated form.
- The expansion is pure combinational logic feeding the output registers. It has no internal state beyond those registers.

## Timing

- Reset (rst_n low, asynchronous): imm32 = 32'h0, carry_out = 0, out_valid = 0, all immediately. Outputs stay in reset while rst_n is low.
- Reset release is sampled at the next rising edge of clk.
- Rising edge with in_valid = 1: imm32 and carry_out load the expansion of the imm12/carry_in present at that edge; out_valid becomes 1.
  - Latency is exactly 1 cycle. Throughput is one input per cycle with no stalls or backpressure.
- Rising edge with in_valid = 0: imm32 and carry_out hold their previous values; out_valid becomes 0.
- Back-to-back valid inputs produce back-to-back results in order. No bubble is inserted.
- If rst_n asserts mid-stream, any in-flight result is discarded. The first valid input after release produces a result one cycle later.

## Test plan

- Replicated forms, carry_in = 1, one input per cycle:
  - imm12 = 0x0AB, 0x1AB, 0x2AB, 0x3AB -> imm32 = 0x000000AB, 0x00AB00AB, 0xAB00AB00, 0xABABABAB on consecutive cycles.
  - carry_out = 1 on every cycle.
  - Repeat with carry_in = 0 -> carry_out = 0.
- Rotated forms:
  - imm12 = 0x400 -> imm32 = 0x80000000, carry_out = 1.
  - imm12 = 0x47F -> imm32 = 0xFF000000, carry_out = 1.
  - imm12 = 0xFFF -> imm32 = 0x000001FE, carry_out = 0.
  - All three hold regardless of carry_in.
- UNPREDICTABLE encodings: imm12 = 0x100 and 0x300 with carry_in = 1 -> imm32 = 0x00000000, carry_out = 1.
- Exhaustive sweep: all 8192 {carry_in, imm12} combinations with in_valid = 1 every cycle.
  - Compare against a reference model with a 1-cycle delay.
  - out_valid = 1 throughout after the first edge.
- Handshake and hold:
  - Apply imm12 = 0x3AB, then in_valid = 0 for 3 cycles with imm12 changing.
  - Required: imm32 holds 0xABABABAB; out_valid is 1 for one cycle, then 0.
- Reset:
  - Drive rst_n low asynchronously between clock edges while imm32 = 0xABABABAB.
  - Required: imm32 = 0, carry_out = 0, out_valid = 0 immediately.
  - After release, the first valid input (0x400) yields 0x80000000 one cycle later.
